// File: rtl/rsa_modexp_core.sv
// Modular exponentiation engine: result = base^exp mod n, using one bit-serial
// interleaved modular multiplier shared between the multiply and square steps.
module rsa_modexp_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_REDUCE, S_CHECK, S_MUL, S_SQR, S_FIN, S_ERR
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_exp_sh;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_a;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic             w_last;
    logic             w_sq_skip;
    logic [WIDTH:0]   w_n_ext;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH:0]   w_p2;
    logic [WIDTH:0]   w_p3;
    logic [WIDTH:0]   w_p4;
    logic [WIDTH-1:0] w_mul;

    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_sq_skip = (r_exp_sh[WIDTH-1:1] == '0);
    assign w_n_ext   = {1'b0, r_n};

    // Restoring division step: r_p holds the partial remainder, r_a shifts the dividend out MSB-first.
    assign w_rem_sh = {r_p, r_a[WIDTH-1]};
    assign w_rem    = WIDTH'((w_rem_sh >= w_n_ext) ? (w_rem_sh - w_n_ext) : w_rem_sh);

    // Interleaved multiply step: P = 2P mod n, then P = (P + a_i*base) mod n. Both partials stay below 2n.
    assign w_p2  = {r_p, 1'b0};
    assign w_p3  = (w_p2 >= w_n_ext) ? (w_p2 - w_n_ext) : w_p2;
    assign w_p4  = w_p3 + (r_a[WIDTH-1] ? {1'b0, r_base} : '0);
    assign w_mul = WIDTH'((w_p4 >= w_n_ext) ? (w_p4 - w_n_ext) : w_p4);

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;

    // start acts as a request with no ready: it is accepted on any edge where the FSM is IDLE and ignored otherwise.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_state_nxt = (n == '0) ? S_ERR : S_REDUCE;
            S_REDUCE: if (w_last) w_state_nxt = (r_exp_sh == '0) ? S_FIN : S_CHECK;
            S_CHECK:  w_state_nxt = r_exp_sh[0] ? S_MUL : S_SQR;
            S_MUL:    if (w_last) w_state_nxt = S_SQR;
            S_SQR: begin
                if (w_sq_skip)   w_state_nxt = S_FIN;
                else if (w_last) w_state_nxt = S_CHECK;
            end
            S_FIN:    w_state_nxt = S_IDLE;
            S_ERR:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n      <= '0;
            r_exp_sh <= '0;
            r_base   <= '0;
            r_acc    <= '0;
            r_p      <= '0;
            r_a      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n      <= n;
                        r_exp_sh <= mode ? d : e;
                        r_a      <= M;
                        r_p      <= '0;
                        r_cnt    <= '0;
                        r_error  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_REDUCE: begin
                    r_p   <= w_rem;
                    r_a   <= {r_a[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_base <= w_rem;
                        r_acc  <= (r_n == WIDTH'(1)) ? '0 : WIDTH'(1);
                        r_cnt  <= '0;
                    end
                end
                S_CHECK: begin
                    r_p   <= '0;
                    r_cnt <= '0;
                    r_a   <= r_exp_sh[0] ? r_acc : r_base;
                end
                S_MUL: begin
                    r_p   <= w_mul;
                    r_a   <= {r_a[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_acc <= w_mul;
                        r_p   <= '0;
                        r_a   <= r_base;
                        r_cnt <= '0;
                    end
                end
                S_SQR: begin
                    if (w_sq_skip) begin
                        r_exp_sh <= r_exp_sh >> 1;
                    end else begin
                        r_p   <= w_mul;
                        r_a   <= {r_a[WIDTH-2:0], 1'b0};
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_base   <= w_mul;
                            r_exp_sh <= r_exp_sh >> 1;
                            r_cnt    <= '0;
                        end
                    end
                end
                S_FIN: begin
                    r_result <= r_acc;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                S_ERR: begin
                    r_result <= '0;
                    r_error  <= 1'b1;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Bench for rsa_modexp_core: directed RSA vectors on a 32-bit instance and
// random vectors on a 16-bit instance, checked against an arithmetic model.
module tb_rsa_modexp_core;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        s32_start, s32_mode;
    logic [31:0] s32_m, s32_e, s32_d, s32_n, s32_result;
    logic        s32_busy, s32_done, s32_error;

    logic        s16_start, s16_mode;
    logic [15:0] s16_m, s16_e, s16_d, s16_n, s16_result;
    logic        s16_busy, s16_done, s16_error;

    int total = 0;
    int bad   = 0;

    rsa_modexp_core #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .start(s32_start), .mode(s32_mode),
        .M(s32_m), .e(s32_e), .d(s32_d), .n(s32_n),
        .result(s32_result), .busy(s32_busy), .done(s32_done), .error(s32_error)
    );

    rsa_modexp_core #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(s16_start), .mode(s16_mode),
        .M(s16_m), .e(s16_e), .d(s16_d), .n(s16_n),
        .result(s16_result), .busy(s16_busy), .done(s16_done), .error(s16_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Square-and-multiply with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] x, input logic [31:0] nn);
        logic [63:0] r;
        logic [63:0] bb;
        if (nn == 0) return 32'd0;
        r  = 64'd1 % 64'(nn);
        bb = 64'(b) % 64'(nn);
        for (int i = 0; i < 32; i++) begin
            if (x[i]) r = (r * bb) % 64'(nn);
            bb = (bb * bb) % 64'(nn);
        end
        return r[31:0];
    endfunction

    // Edges from the start-accept edge through the edge that raises done, both counted.
    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] nn, input int w);
        int msb;
        int lat;
        if (nn == 0) return 2;
        msb = -1;
        for (int i = 0; i < 32; i++) if (x[i]) msb = i;
        lat = 2 + w;
        for (int i = 0; i <= msb; i++) begin
            lat += 1;
            if (x[i]) lat += w;
            lat += (i < msb) ? w : 1;
        end
        return lat;
    endfunction

    task automatic run_op(input bit sel16, input bit md, input logic [31:0] m_v, input logic [31:0] e_v,
                          input logic [31:0] d_v, input logic [31:0] n_v, input int pulse_at,
                          output logic [31:0] res, output logic err, output int lat,
                          output bit busy_ok, output bit pulse_ok, output bit timed_out);
        int cyc;
        bit seen;
        busy_ok = 1'b1; pulse_ok = 1'b1; seen = 1'b0;
        @(negedge clk);
        if (sel16) begin
            s16_mode = md; s16_m = m_v[15:0]; s16_e = e_v[15:0]; s16_d = d_v[15:0]; s16_n = n_v[15:0];
            s16_start = 1'b1;
        end else begin
            s32_mode = md; s32_m = m_v; s32_e = e_v; s32_d = d_v; s32_n = n_v;
            s32_start = 1'b1;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        s16_start = 1'b0; s32_start = 1'b0;
        cyc = 0;
        while (!seen && cyc < 5000) begin
            if (sel16 ? s16_done : s32_done) begin
                seen = 1'b1;
            end else begin
                if (!(sel16 ? s16_busy : s32_busy)) busy_ok = 1'b0;
                if (cyc == pulse_at) begin
                    if (sel16) begin s16_m = m_v[15:0] ^ 16'h5; s16_start = 1'b1; end
                    else begin s32_m = m_v ^ 32'h5; s32_start = 1'b1; end
                end else begin
                    s16_start = 1'b0; s32_start = 1'b0;
                end
                @(posedge clk);
                lat++;
                @(negedge clk);
                cyc++;
            end
        end
        s16_start = 1'b0; s32_start = 1'b0;
        timed_out = !seen;
        res = sel16 ? {16'h0, s16_result} : s32_result;
        err = sel16 ? s16_error : s32_error;
        if (sel16 ? s16_busy : s32_busy) busy_ok = 1'b0;
        @(negedge clk);
        if (sel16 ? s16_done : s32_done) pulse_ok = 1'b0;
    endtask

    task automatic do_test(input string tag, input bit sel16, input bit md, input logic [31:0] m_v,
                           input logic [31:0] e_v, input logic [31:0] d_v, input logic [31:0] n_v,
                           input int pulse_at, output logic [31:0] res);
        logic        err;
        int          lat;
        bit          busy_ok, pulse_ok, tmo;
        logic [31:0] x;
        run_op(sel16, md, m_v, e_v, d_v, n_v, pulse_at, res, err, lat, busy_ok, pulse_ok, tmo);
        x = md ? d_v : e_v;
        check({tag, ".timeout"}, 64'(tmo), 64'd0);
        check({tag, ".result"}, 64'(res), 64'(ref_modexp(m_v, x, n_v)));
        check({tag, ".error"}, 64'(err), 64'(n_v == 0));
        check({tag, ".latency"}, 64'(lat), 64'(ref_lat(x, n_v, sel16 ? 16 : 32)));
        check({tag, ".busy"}, 64'(busy_ok), 64'd1);
        check({tag, ".pulse"}, 64'(pulse_ok), 64'd1);
    endtask

    initial begin
        logic [31:0] res;
        bit          saw_done;

        reset_n = 1'b0;
        s32_start = 1'b0; s32_mode = 1'b0; s32_m = '0; s32_e = '0; s32_d = '0; s32_n = '0;
        s16_start = 1'b0; s16_mode = 1'b0; s16_m = '0; s16_e = '0; s16_d = '0; s16_n = '0;
        repeat (3) @(negedge clk);
        check("rst.result32", 64'(s32_result), 64'd0);
        check("rst.busy32",   64'(s32_busy),   64'd0);
        check("rst.done32",   64'(s32_done),   64'd0);
        check("rst.error32",  64'(s32_error),  64'd0);
        check("rst.result16", 64'(s16_result), 64'd0);
        check("rst.busy16",   64'(s16_busy),   64'd0);
        check("rst.done16",   64'(s16_done),   64'd0);
        check("rst.error16",  64'(s16_error),  64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        do_test("T1", 1'b0, 1'b0, 32'd65, 32'd17, 32'd0, 32'd3233, -1, res);
        check("T1.lit", 64'(res), 64'd2790);
        repeat (3) @(negedge clk);
        check("T1.hold", 64'(s32_result), 64'd2790);

        do_test("T2", 1'b0, 1'b1, 32'd2790, 32'd17, 32'd2753, 32'd3233, -1, res);
        check("T2.lit", 64'(res), 64'd65);
        do_test("T3a", 1'b0, 1'b0, 32'd3298, 32'd17, 32'd0, 32'd3233, -1, res);
        check("T3a.lit", 64'(res), 64'd2790);
        do_test("T3b", 1'b0, 1'b0, 32'd65, 32'd0, 32'd0, 32'd3233, -1, res);
        check("T3b.lit", 64'(res), 64'd1);
        do_test("T3c", 1'b0, 1'b0, 32'd65, 32'd0, 32'd0, 32'd1, -1, res);
        check("T3c.lit", 64'(res), 64'd0);

        do_test("T4", 1'b0, 1'b0, 32'd65, 32'd17, 32'd0, 32'd0, -1, res);
        check("T4.lit", 64'(res), 64'd0);
        check("T4.err_hold", 64'(s32_error), 64'd1);
        do_test("T4b", 1'b0, 1'b0, 32'd65, 32'd17, 32'd0, 32'd3233, -1, res);
        check("T4b.lit", 64'(res), 64'd2790);

        do_test("T5", 1'b0, 1'b0, 32'd65, 32'd17, 32'd0, 32'd3233, 10, res);
        check("T5.lit", 64'(res), 64'd2790);

        // Abort an operation while the multiplier is running.
        @(negedge clk);
        s32_mode = 1'b0; s32_m = 32'd65; s32_e = 32'd17; s32_n = 32'd3233; s32_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s32_start = 1'b0;
        repeat (36) @(negedge clk);
        check("RST.busy_before", 64'(s32_busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("RST.result", 64'(s32_result), 64'd0);
        check("RST.busy",   64'(s32_busy),   64'd0);
        check("RST.done",   64'(s32_done),   64'd0);
        check("RST.error",  64'(s32_error),  64'd0);
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (s32_done) saw_done = 1'b1;
        end
        reset_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (s32_done || s32_busy) saw_done = 1'b1;
        end
        check("RST.no_done", 64'(saw_done), 64'd0);
        do_test("T5b", 1'b0, 1'b0, 32'd65, 32'd17, 32'd0, 32'd3233, -1, res);
        check("T5b.lit", 64'(res), 64'd2790);

        for (int v = 0; v < 120; v++) begin
            int unsigned sel;
            logic [31:0] nv, mv, ev, dv;
            bit          md;
            sel = $urandom_range(0, 9);
            mv  = $urandom_range(0, 65535);
            ev  = $urandom_range(0, 65535);
            dv  = $urandom_range(0, 65535);
            md  = 1'($urandom_range(0, 1));
            case (sel)
                0:       nv = 32'd0;
                1:       nv = 32'd1;
                2:       nv = $urandom_range(2, 20);
                3:       begin nv = $urandom_range(2, 65535); ev = $urandom_range(0, 3); dv = $urandom_range(0, 3); end
                default: nv = $urandom_range(2, 65535);
            endcase
            do_test($sformatf("R16_%0d", v), 1'b1, md, mv, ev, dv, nv, -1, res);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
